// File: rtl/decode_issue_queue_if.sv
// ----------------------------------------------------------------------------
// decode_issue_queue_if
//   Handshake bundle between the decode stage and the execute stage around the
//   decode/issue queue.
//   master : decode/execute side (drives in_valid, in_hazard, in_payload,
//            out_ready; observes in_ready, out_valid, out_payload)
//   slave  : the queue itself
// ----------------------------------------------------------------------------
interface decode_issue_queue_if #(
    parameter int PAYLOAD_W = 128
);
    logic                 in_valid;
    logic                 in_hazard;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_ready;

    modport master (
        output in_valid, in_hazard, in_payload, out_ready,
        input  in_ready, out_valid, out_payload
    );

    modport slave (
        input  in_valid, in_hazard, in_payload, out_ready,
        output in_ready, out_valid, out_payload
    );
endinterface

// File: rtl/decode_issue_queue.sv
// ----------------------------------------------------------------------------
// decode_issue_queue
//   In-order buffer of DEPTH decoded-instruction bundles sitting between decode
//   and execute. Valid/ready on both sides, hazard bubble insertion, flush on
//   redirect, and a saturating counter of cycles where execute was ready but
//   received a NOP (empty queue presents an all-zero bundle).
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   bus        : decode/execute handshake bundle (slave side)
//   flush      : discard all queued entries on this edge
//   count      : current occupancy 0..DEPTH
//   bubble_cnt : saturating count of ready-but-empty cycles
// ----------------------------------------------------------------------------
module decode_issue_queue #(
    parameter int PAYLOAD_W = 128,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    decode_issue_queue_if.slave      bus,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         bubble_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [OCC_W-1:0]     count_q;
    logic [OCC_W-1:0]     count_d;
    logic [CNT_W-1:0]     bubble_q;
    logic [PAYLOAD_W-1:0] mem_q [DEPTH];

    logic in_ready_w;
    logic out_valid_w;
    logic push;
    logic pop;

    // Occupancy state drives the handshakes; out_ready never feeds in_ready.
    always_comb begin
        out_valid_w = (state_q != ST_EMPTY);
        in_ready_w  = (state_q != ST_FULL) & ~bus.in_hazard & ~flush;
        push        = bus.in_valid & in_ready_w;
        // A flush edge discards everything, so nothing is considered consumed.
        pop         = out_valid_w & bus.out_ready & ~flush;
        count_d     = count_q + OCC_W'(push) - OCC_W'(pop);
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_w;
    // Empty queue hands execute a NOP; stale storage after a flush is masked here.
    assign bus.out_payload = out_valid_w ? mem_q[rd_ptr_q] : '0;
    assign count           = count_q;
    assign bubble_cnt      = bubble_q;

    // Occupancy FSM, pointers and bubble counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= '0;
        end else begin
            // Bubble accounting survives flushes.
            if (bus.out_ready && !out_valid_w && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end

            if (flush) begin
                state_q  <= ST_EMPTY;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                // Power-of-two depth: pointers wrap naturally.
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
                if (count_d == '0) begin
                    state_q <= ST_EMPTY;
                end else if (count_d == OCC_W'(DEPTH)) begin
                    state_q <= ST_FULL;
                end else begin
                    state_q <= ST_PARTIAL;
                end
            end
        end
    end

    // Entry storage: one register bank per slot, written when the write
    // pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= bus.in_payload;
                end
            end
        end
    endgenerate

endmodule
